// File: rtl/fpga_config_ctrl.sv
// rtl/fpga_config_ctrl.sv - streams a bitstream from memory into parallel configuration chains
// Sequences prog_rst/fpga_rst around the load; supports reconfigure, abort and a divided shift rate.
module fpga_config_ctrl #(
    parameter int NUM_CHAINS       = 1,
    parameter int BITSTREAM_LENGTH = 7286,
    parameter int SETTLE_CYCLES    = 16,
    parameter int CLK_DIV          = 2,
    parameter bit AUTO_START       = 1'b1,
    parameter int ADDR_W           = (BITSTREAM_LENGTH > 1) ? $clog2(BITSTREAM_LENGTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cfg_start_i,
    input  logic                  cfg_abort_i,
    output logic                  mem_rd_en_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    input  logic [NUM_CHAINS-1:0] mem_rdata_i,
    output logic [NUM_CHAINS-1:0] prog_o,
    output logic                  prog_en_o,
    output logic                  prog_rst_o,
    output logic                  fpga_rst_o,
    output logic                  busy_o,
    output logic                  config_done_o,
    output logic                  cfg_aborted_o
);

    localparam int WC_W = $clog2(BITSTREAM_LENGTH + 1);
    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int DC_W = $clog2(CLK_DIV);

    localparam logic [WC_W-1:0] WC_LEN  = WC_W'(BITSTREAM_LENGTH);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(BITSTREAM_LENGTH - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_LOAD,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [SC_W-1:0]         settle_q;
    logic [DC_W-1:0]         div_q;
    logic [WC_W-1:0]         word_q;
    logic                    rd_pend_q;
    logic [NUM_CHAINS-1:0]   prog_q;
    logic                    prog_en_q;
    logic                    aborted_q;
    logic                    auto_q;
    logic                    rd_issue_d;
    logic                    abort_d;

    assign rd_issue_d = (state_q == S_LOAD) && (div_q == '0) && (word_q < WC_LEN);
    assign abort_d    = cfg_abort_i &&
                        ((state_q == S_SETTLE) || (state_q == S_LOAD) || (state_q == S_FLUSH));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            settle_q  <= '0;
            div_q     <= '0;
            word_q    <= '0;
            rd_pend_q <= 1'b0;
            prog_q    <= '0;
            prog_en_q <= 1'b0;
            aborted_q <= 1'b0;
            auto_q    <= AUTO_START;
        end else begin
            prog_en_q <= 1'b0;
            rd_pend_q <= 1'b0;
            if (abort_d) begin
                // Dropping rd_pend_q discards any read whose data is still in flight.
                state_q   <= S_IDLE;
                aborted_q <= 1'b1;
                word_q    <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (cfg_start_i || auto_q) begin
                            state_q   <= S_SETTLE;
                            settle_q  <= '0;
                            auto_q    <= 1'b0;
                            aborted_q <= 1'b0;
                        end
                    end
                    S_SETTLE: begin
                        if (settle_q == SC_LAST) begin
                            state_q <= S_LOAD;
                            div_q   <= '0;
                            word_q  <= '0;
                        end else begin
                            settle_q <= settle_q + SC_W'(1);
                        end
                    end
                    S_LOAD, S_FLUSH: begin
                        if (rd_pend_q) begin
                            prog_q    <= mem_rdata_i;
                            prog_en_q <= 1'b1;
                        end
                        if (state_q == S_LOAD) begin
                            div_q <= (div_q == DC_LAST) ? '0 : div_q + DC_W'(1);
                            if (rd_issue_d) begin
                                word_q    <= word_q + WC_W'(1);
                                rd_pend_q <= 1'b1;
                                if (word_q == WC_LAST) begin
                                    state_q <= S_FLUSH;
                                end
                            end
                        end else if (prog_en_q && !rd_pend_q) begin
                            state_q <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        if (cfg_start_i) begin
                            state_q   <= S_SETTLE;
                            settle_q  <= '0;
                            aborted_q <= 1'b0;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign mem_rd_en_o   = rd_issue_d;
    assign mem_addr_o    = word_q[ADDR_W-1:0];
    assign prog_o        = prog_q;
    assign prog_en_o     = prog_en_q;
    assign prog_rst_o    = (state_q == S_IDLE) || (state_q == S_SETTLE);
    assign fpga_rst_o    = (state_q != S_DONE);
    assign busy_o        = (state_q == S_SETTLE) || (state_q == S_LOAD) || (state_q == S_FLUSH);
    assign config_done_o = (state_q == S_DONE);
    assign cfg_aborted_o = aborted_q;

endmodule

// File: tb/tb_fpga_config_ctrl.sv
// tb/tb_fpga_config_ctrl.sv - self-checking bench for fpga_config_ctrl against a cycle-arithmetic model
module tb_fpga_config_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfg_start = 1'b0;
    logic cfg_abort = 1'b0;
    always #5 clk = ~clk;

    logic       rd0, en0, prst0, frst0, busy0, done0, abo0;
    logic [2:0] addr0, prog0, rdata0;
    logic       rd1, en1, prst1, frst1, busy1, done1, abo1;
    logic [0:0] addr1;
    logic [1:0] prog1, rdata1;

    fpga_config_ctrl #(.NUM_CHAINS(3), .BITSTREAM_LENGTH(5), .SETTLE_CYCLES(4),
                       .CLK_DIV(2), .AUTO_START(1'b1)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .cfg_start_i(cfg_start), .cfg_abort_i(cfg_abort),
        .mem_rd_en_o(rd0), .mem_addr_o(addr0), .mem_rdata_i(rdata0), .prog_o(prog0),
        .prog_en_o(en0), .prog_rst_o(prst0), .fpga_rst_o(frst0), .busy_o(busy0),
        .config_done_o(done0), .cfg_aborted_o(abo0));

    fpga_config_ctrl #(.NUM_CHAINS(2), .BITSTREAM_LENGTH(1), .SETTLE_CYCLES(3),
                       .CLK_DIV(5), .AUTO_START(1'b0)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .cfg_start_i(cfg_start), .cfg_abort_i(cfg_abort),
        .mem_rd_en_o(rd1), .mem_addr_o(addr1), .mem_rdata_i(rdata1), .prog_o(prog1),
        .prog_en_o(en1), .prog_rst_o(prst1), .fpga_rst_o(frst1), .busy_o(busy1),
        .config_done_o(done1), .cfg_aborted_o(abo1));

    int S_P[2]    = '{4, 3};
    int L_P[2]    = '{5, 1};
    int D_P[2]    = '{2, 5};
    int AUTO_P[2] = '{1, 0};
    int MASK_P[2] = '{7, 3};
    int mem[2][5];

    always @(posedge clk) begin
        if (rd0) rdata0 <= 3'(mem[0][int'(addr0)]);
        if (rd1) rdata1 <= 2'(mem[1][int'(addr1)]);
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int d, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%0d want=%0d", nm, d, cyc, act, expv);
        end
    endtask

    typedef struct {
        int prst, frst, busy, done, en, rd, addr, k;
    } exp_t;

    // Expected outputs from the load timeline measured from the first SETTLE cycle t.
    function automatic exp_t model(input int d, input bit a, input int t, input int c);
        exp_t e;
        int rel, s, dv, l;
        s = S_P[d]; dv = D_P[d]; l = L_P[d];
        e = '{1, 1, 0, 0, 0, 0, 0, 0};
        if (a) begin
            rel = c - t;
            if (rel >= s + (l - 1) * dv + 3) begin
                e.prst = 0; e.frst = 0; e.done = 1;
            end else begin
                e.busy = 1;
                e.prst = (rel < s) ? 1 : 0;
                if (rel >= s && (rel - s) % dv == 0 && (rel - s) / dv < l) begin
                    e.rd = 1; e.addr = (rel - s) / dv;
                end
                if (rel >= s + 2 && (rel - s - 2) % dv == 0 && (rel - s - 2) / dv < l) begin
                    e.en = 1; e.k = (rel - s - 2) / dv;
                end
            end
        end
        return e;
    endfunction

    bit m_act[2];
    int m_t0[2];
    bit m_ab[2];
    bit m_auto[2] = '{1'b1, 1'b0};
    int m_prog[2];
    int o_rd[2], o_addr[2], o_prog[2], o_en[2], o_prst[2], o_frst[2], o_busy[2], o_done[2], o_abo[2];
    exp_t ev;

    always @(negedge clk) begin
        o_rd[0] = int'(rd0);   o_rd[1] = int'(rd1);
        o_addr[0] = int'(addr0); o_addr[1] = int'(addr1);
        o_prog[0] = int'(prog0); o_prog[1] = int'(prog1);
        o_en[0] = int'(en0);   o_en[1] = int'(en1);
        o_prst[0] = int'(prst0); o_prst[1] = int'(prst1);
        o_frst[0] = int'(frst0); o_frst[1] = int'(frst1);
        o_busy[0] = int'(busy0); o_busy[1] = int'(busy1);
        o_done[0] = int'(done0); o_done[1] = int'(done1);
        o_abo[0] = int'(abo0); o_abo[1] = int'(abo1);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_act[d] = 1'b0; m_ab[d] = 1'b0; m_prog[d] = 0;
                m_auto[d] = (AUTO_P[d] != 0);
                ev = model(d, 1'b0, 0, cyc);
                chk("rst_addr", d, o_addr[d], 0);
            end else begin
                ev = model(d, m_act[d], m_t0[d], cyc);
                if (ev.en != 0) m_prog[d] = mem[d][ev.k] & MASK_P[d];
                if (ev.rd != 0) chk("mem_addr", d, o_addr[d], ev.addr);
            end
            chk("mem_rd_en", d, o_rd[d], ev.rd);
            chk("prog_en", d, o_en[d], ev.en);
            chk("prog", d, o_prog[d], m_prog[d]);
            chk("prog_rst", d, o_prst[d], ev.prst);
            chk("fpga_rst", d, o_frst[d], ev.frst);
            chk("busy", d, o_busy[d], ev.busy);
            chk("config_done", d, o_done[d], ev.done);
            chk("cfg_aborted", d, o_abo[d], int'(m_ab[d]));
            if (rst_n) begin
                if (!m_act[d]) begin
                    if (cfg_start || m_auto[d]) begin
                        m_act[d] = 1'b1; m_t0[d] = cyc + 1; m_ab[d] = 1'b0; m_auto[d] = 1'b0;
                    end
                end else if (ev.busy != 0) begin
                    if (cfg_abort) begin
                        m_act[d] = 1'b0; m_ab[d] = 1'b1;
                    end
                end else if (cfg_start) begin
                    m_t0[d] = cyc + 1; m_ab[d] = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
    endtask

    // Called right after the start/release cycle; observes one full 5-word load of dut0.
    task automatic obs_load(input bit chk1);
        int en_rel[$], en_val[$], rd_rel[$], rd_adr[$], en1_rel[$];
        int done_rel, prst_rel, done1_rel;
        done_rel = -1; prst_rel = -1; done1_rel = -1;
        for (int i = -1; i < 20; i++) begin
            @(negedge clk);
            if (en0) begin en_rel.push_back(i); en_val.push_back(int'(prog0)); end
            if (rd0) begin rd_rel.push_back(i); rd_adr.push_back(int'(addr0)); end
            if (i >= 0 && done0 && done_rel < 0) done_rel = i;
            if (i >= 0 && !prst0 && prst_rel < 0) prst_rel = i;
            if (en1) en1_rel.push_back(i);
            if (i >= 0 && done1 && done1_rel < 0) done1_rel = i;
            if (i == 0) begin
                chk("lit_done_low", 0, int'(done0), 0);
                chk("lit_fpga_rst_high", 0, int'(frst0), 1);
                chk("lit_aborted_clr", 0, int'(abo0), 0);
            end
            tick();
        end
        chk("lit_en_count", 0, en_rel.size(), 5);
        chk("lit_rd_count", 0, rd_rel.size(), 5);
        for (int j = 0; j < 5; j++) begin
            chk("lit_en_cycle", 0, (j < en_rel.size()) ? en_rel[j] : -1, 6 + 2 * j);
            chk("lit_en_data", 0, (j < en_val.size()) ? en_val[j] : -1, j);
            chk("lit_rd_cycle", 0, (j < rd_rel.size()) ? rd_rel[j] : -1, 4 + 2 * j);
            chk("lit_rd_addr", 0, (j < rd_adr.size()) ? rd_adr[j] : -1, j);
        end
        chk("lit_done_cycle", 0, done_rel, 15);
        chk("lit_prog_rst_fall", 0, prst_rel, 4);
        if (chk1) begin
            chk("lit_en_count", 1, en1_rel.size(), 1);
            chk("lit_en_cycle", 1, (en1_rel.size() > 0) ? en1_rel[0] : -1, 5);
            chk("lit_done_cycle", 1, done1_rel, 6);
        end
    endtask

    initial begin
        int n;
        exp_t pe;
        for (int k = 0; k < 5; k++) begin mem[0][k] = k; mem[1][k] = 2; end

        pe = model(0, 1'b1, 0, 14);
        chk("model_en_last", 0, pe.en * 10 + pe.k, 14);
        pe = model(0, 1'b1, 0, 15);
        chk("model_done", 0, pe.done * 10 + pe.frst, 10);
        pe = model(1, 1'b1, 0, 3);
        chk("model_rd_l1", 1, pe.rd * 10 + pe.prst, 10);

        repeat (3) tick();
        rst_n = 1'b1;
        obs_load(1'b0);
        n = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            @(negedge clk);
            if (rd1 || en1 || busy1 || done1 || !prst1 || !frst1) n++;
        end
        chk("lit_idle_noauto", 1, n, 0);

        tick(); cfg_start = 1'b1;
        obs_load(1'b1);

        tick(); cfg_start = 1'b1;
        repeat (6) tick();
        cfg_start = 1'b1;
        repeat (3) tick();
        cfg_abort = 1'b1;
        @(negedge clk);
        chk("lit_third_read", 0, int'(rd0) * 10 + int'(addr0), 12);
        tick();
        @(negedge clk);
        chk("lit_abort_idle", 0, int'(busy0) * 100 + int'(prst0) * 10 + int'(frst0), 11);
        chk("lit_abort_flag", 0, int'(abo0), 1);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            @(negedge clk);
            if (en0) n++;
        end
        chk("lit_abort_no_en", 0, n, 0);
        tick(); cfg_start = 1'b1;
        obs_load(1'b1);

        tick(); cfg_start = 1'b1;
        repeat (7) tick();
        cfg_start = 1'b1; cfg_abort = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("lit_abort_wins", 0, int'(busy0) * 10 + int'(abo0), 1);

        tick(); cfg_start = 1'b1;
        repeat (8) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("lit_async_rst", 0,
            int'(prog0) * 1000000 + int'(en0) * 100000 + int'(prst0) * 10000 +
            int'(frst0) * 1000 + int'(busy0) * 100 + int'(rd0) * 10 + int'(addr0), 11000);
        tick();
        rst_n = 1'b1;
        obs_load(1'b0);

        for (int i = 0; i < 3000; i++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                pe = model(d, m_act[d], m_t0[d], cyc);
                if (pe.busy == 0 && $urandom_range(0, 7) == 0)
                    for (int k = 0; k < 5; k++) mem[d][k] = int'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 399) == 0) begin
                #($urandom_range(1, 3));
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end else begin
                cfg_start = ($urandom_range(0, 15) == 0);
                cfg_abort = ($urandom_range(0, 29) == 0);
            end
        end
        tick();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpga_config_ctrl.md
# fpga_config_ctrl

Parametrised configuration controller for the eFPGA fabric. It streams a bitstream from an external synchronous memory into NUM_CHAINS parallel configuration chains and sequences prog_rst/fpga_rst around the load. Beyond power-on loading, it supports on-demand reconfiguration, abort, and a programmable shift rate. It sits between the SoC control registers / bitstream memory and the fabric's programming ports.

## Interface
- NUM_CHAINS, 1: number of parallel configuration chains; bit i of each memory word feeds chain i
- BITSTREAM_LENGTH, 7286: words (bits per chain) per configuration, ≥1
- SETTLE_CYCLES, 16: cycles held in SETTLE with both resets asserted, ≥1
- CLK_DIV, 2: clk cycles per shift step, ≥2
- AUTO_START, 1: 1 = begin loading after reset release without cfg_start
- ADDR_W, max(1,$clog2(BITSTREAM_LENGTH)): memory address width
- clk  in  1  single clock
- rst  in  1  asynchronous, active-low reset
- cfg_start  in  1  start/reconfigure request, level-sampled
- cfg_abort  in  1  abort request, level-sampled
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  word address
- mem_rdata  in  NUM_CHAINS  read data, valid exactly one cycle after mem_rd_en
- prog  out  NUM_CHAINS  chain data
- prog_en  out  1  one-cycle shift strobe qualifying prog
- prog_rst  out  1  chain reset, active-high
- fpga_rst  out  1  fabric reset, active-high
- busy  out  1  high in SETTLE/LOAD/FLUSH
- config_done  out  1  high only in DONE
- cfg_aborted  out  1  sticky abort flag

## Operation
- All outputs registered or decoded from state registers; no input-to-output combinational path.
- Reset values: prog=0, prog_en=0, prog_rst=1, fpga_rst=1, busy=0, config_done=0, cfg_aborted=0, mem_rd_en=0, mem_addr=0, state=IDLE.
- States: IDLE, SETTLE, LOAD, FLUSH, DONE.
- IDLE: prog_rst=1, fpga_rst=1. Goes to SETTLE on cfg_start, or on the first cycle after reset release when AUTO_START=1.
- SETTLE: prog_rst=1, fpga_rst=1, busy=1. Settle counter runs SETTLE_CYCLES cycles, then LOAD. The counter clears on entry.
- LOAD: prog_rst=0, fpga_rst=1. div_cnt cycles 0..CLK_DIV-1.
  - When div_cnt==0 and word_cnt<BITSTREAM_LENGTH: mem_rd_en=1, mem_addr=word_cnt, and word_cnt increments.
  - One cycle later mem_rdata is captured into prog, and prog_en pulses in the following cycle.
  - After the last read is issued, go to FLUSH.
- FLUSH: waits until the final prog_en has been driven, then goes to DONE.
- DONE: fpga_rst=0, prog_rst=0, config_done=1, busy=0. cfg_start here restarts the load: fpga_rst=1 and config_done=0 from the next cycle, state becomes SETTLE.
- cfg_start while busy is ignored.
- cfg_abort in SETTLE/LOAD/FLUSH:
  - next cycle state=IDLE, prog_rst=1, fpga_rst=1, prog_en=0, mem_rd_en=0, and cfg_aborted=1;
  - any in-flight read data is discarded;
  - abort has priority over a simultaneous cfg_start;
  - cfg_abort in IDLE/DONE has no effect.
- cfg_aborted clears when a start is accepted. AUTO_START does not re-fire after an abort.
- word_cnt is $clog2(BITSTREAM_LENGTH+1) bits wide and never wraps. prog holds its last value between strobes.
- Asserting rst at any point returns all outputs to their reset values asynchronously.

## Timing
- Take cycle 0 as the first SETTLE cycle (the cycle after start is accepted).
- LOAD starts in cycle S=SETTLE_CYCLES.
- Read k (k=0..L-1) occurs in cycle S+k·CLK_DIV. Its prog_en occurs in cycle S+k·CLK_DIV+2, with prog=word k.
- config_done rises, and fpga_rst falls, in cycle S+(L-1)·CLK_DIV+3.
- Exactly BITSTREAM_LENGTH prog_en pulses occur per completed load. No two are adjacent when CLK_DIV≥2.

## Test plan
- Power-on with AUTO_START=1, SETTLE_CYCLES=4, L=5, CLK_DIV=2, NUM_CHAINS=3, memory word k = k: expect reads in cycles 4,6,8,10,12; prog_en in cycles 6,8,10,12,14 with prog=0..4; config_done=1 and fpga_rst=0 in cycle 15; prog_rst=0 from cycle 4.
- AUTO_START=0: no activity and outputs at reset values for 100 cycles. A cfg_start pulse then produces the full sequence above, offset by the acceptance cycle.
- cfg_abort during the third read: next cycle IDLE, prog_rst=fpga_rst=1, cfg_aborted=1, no further prog_en. A later cfg_start clears cfg_aborted and delivers all 5 words from address 0.
- cfg_start in DONE: config_done drops and fpga_rst rises the next cycle, followed by a complete reload of 5 words. cfg_start pulses during LOAD change nothing.
- Simultaneous cfg_start and cfg_abort in LOAD: abort wins and the state is IDLE.
- rst asserted mid-LOAD, asynchronously (not aligned to clk): outputs reach reset values immediately. After release with AUTO_START=1, loading restarts at address 0. L=1 and CLK_DIV=5: one prog_en in cycle S+2, config_done in cycle S+3.
